// File: rtl/srt_div_r2_seq.sv
// Sequential radix-2 SRT divider: normalise divisor, retire one digit {-1,0,+1} per clock.
// Define SRT_DIV_SIGNED_EN for two's-complement operands with truncation toward zero.
module srt_div_r2_seq #(
  parameter int WID = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WID-1:0] op1_i,
  input  logic [WID-1:0] op2_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WID-1:0] quo_o,
  output logic [WID-1:0] rem_o,
  output logic           dbz_o
);
  localparam int RW = WID + 3;
  localparam int SW = $clog2(WID);
  localparam int CW = $clog2(WID + 1);

  typedef enum logic [2:0] {IDLE, NORM, ITER, CORR, DONE} state_t;
  state_t state;

  logic [WID-1:0]       dvd, dvs, qp, qm;
  logic [SW-1:0]        sh;
  logic [CW-1:0]        cnt;
  logic signed [RW-1:0] r, r2, dd, r_nxt, r_fix;
  logic [2:0]           top;
  logic                 qpos, qneg;
  logic [WID-1:0]       mag1, mag2, q_raw, q_fix, rem_mag, q_out, rem_out;

  function automatic logic [SW-1:0] lzc(input logic [WID-1:0] v);
    lzc = '0;
    for (int i = 0; i < WID; i++)
      if (v[i]) lzc = SW'(WID - 1 - i);
  endfunction

`ifdef SRT_DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign mag1    = op1_i[WID-1] ? -op1_i : op1_i;
  assign mag2    = op2_i[WID-1] ? -op2_i : op2_i;
  assign q_out   = neg_q ? -q_fix : q_fix;
  assign rem_out = neg_r ? -rem_mag : rem_mag;
`else
  assign mag1    = op1_i;
  assign mag2    = op2_i;
  assign q_out   = q_fix;
  assign rem_out = rem_mag;
`endif

  assign in_ready = (state == IDLE);

  // r holds the partial remainder scaled by two, so the divisor step is d << 1
  // and the half-LSB of the dividend is never lost.
  assign dd  = RW'({dvs, 1'b0});
  assign r2  = r <<< 1;
  assign top = r2[RW-1:RW-3];

  always_comb begin
    qpos  = !top[2] && (top != 3'b000);
    qneg  = top[2] && (top != 3'b111);
    r_nxt = r2;
    if (qpos)      r_nxt = r2 - dd;
    else if (qneg) r_nxt = r2 + dd;
  end

  assign q_raw   = qp - qm;
  assign q_fix   = r[RW-1] ? q_raw - 1'b1 : q_raw;
  assign r_fix   = r[RW-1] ? r + dd : r;
  assign rem_mag = WID'(r_fix >> ({1'b0, sh} + 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      quo_o     <= '0;
      rem_o     <= '0;
      dbz_o     <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      qp        <= '0;
      qm        <= '0;
      sh        <= '0;
      cnt       <= '0;
      r         <= '0;
`ifdef SRT_DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd <= mag1;
          dvs <= mag2;
`ifdef SRT_DIV_SIGNED_EN
          neg_q <= op1_i[WID-1] ^ op2_i[WID-1];
          neg_r <= op1_i[WID-1];
`endif
          if (op2_i == '0) begin
            quo_o     <= '1;
            rem_o     <= op1_i;
            dbz_o     <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            dbz_o <= 1'b0;
            state <= NORM;
          end
        end
        NORM: begin
          sh    <= lzc(dvs);
          dvs   <= dvs << lzc(dvs);
          r     <= RW'(dvd);
          qp    <= '0;
          qm    <= '0;
          cnt   <= CW'(lzc(dvs)) + 1'b1;
          state <= ITER;
        end
        ITER: begin
          r   <= r_nxt;
          qp  <= {qp[WID-2:0], qpos};
          qm  <= {qm[WID-2:0], qneg};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= CORR;
        end
        CORR: begin
          quo_o     <= q_out;
          rem_o     <= rem_out;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
